// File: rtl/calc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : calc_sequencer
// Purpose  : Command sequencer for the 8-bit calculator datapath. Commands
//            {ope, uas, a, b} are accepted on a valid/ready channel into an
//            in-order queue, issued one at a time to the external
//            combinational ALU mux, and the result is returned on a
//            valid/ready response channel with a range-error flag. The
//            sequencer owns the accumulator that feeds the ALU res input.
// Ports    : clk, rst (async, active-low)
//            cmd_valid/cmd_ready, cmd_ope[2:0], cmd_uas, cmd_a, cmd_b
//            alu_ope, alu_uas, alu_in1, alu_in2, alu_res -> ALU, alu_ans <- ALU
//            rsp_valid/rsp_ready, rsp_data, rsp_err
//            acc (accumulator), busy
// Revision : 1.0  initial release
// ============================================================================
module calc_sequencer #(
  parameter int DEPTH = 4,
  parameter int n     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [2:0]   cmd_ope,
  input  logic         cmd_uas,
  input  logic [n-1:0] cmd_a,
  input  logic [n-1:0] cmd_b,
  output logic [2:0]   alu_ope,
  output logic         alu_uas,
  output logic [n-1:0] alu_in1,
  output logic [n-1:0] alu_in2,
  output logic [n-1:0] alu_res,
  input  logic [n-1:0] alu_ans,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [n-1:0] rsp_data,
  output logic         rsp_err,
  output logic [n-1:0] acc,
  output logic         busy
);

  localparam int c_AW = $clog2(DEPTH);
  localparam int c_CW = c_AW + 1;
  localparam logic [c_CW-1:0] c_DEPTH = c_CW'(DEPTH);
  // Largest in-range result, held at double width for the error compare.
  localparam logic [2*n-1:0] c_LIMIT = {{n{1'b0}}, {n{1'b1}}};

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_ISSUE = 2'd1;
  localparam logic [1:0] c_RESP  = 2'd2;

  localparam logic [2:0] c_OP_ADD = 3'b001;
  localparam logic [2:0] c_OP_SUB = 3'b010;
  localparam logic [2:0] c_OP_MUL = 3'b011;

  // Queue storage and pointers
  logic [2:0]      r_mem_ope [DEPTH];
  logic            r_mem_uas [DEPTH];
  logic [n-1:0]    r_mem_a   [DEPTH];
  logic [n-1:0]    r_mem_b   [DEPTH];
  logic [c_AW-1:0] r_wptr;
  logic [c_AW-1:0] r_rptr;
  logic [c_CW-1:0] r_count;

  // Command register (the command currently being issued / answered)
  logic [1:0]      r_state;
  logic [2:0]      r_c_ope;
  logic            r_c_uas;
  logic [n-1:0]    r_c_a;
  logic [n-1:0]    r_c_b;
  logic [n-1:0]    r_acc;
  logic [n-1:0]    r_rsp_data;
  logic            r_rsp_err;

  logic            w_push;
  logic            w_pop;
  logic            w_have;
  logic            w_issue;
  logic [2*n-1:0]  w_a16;
  logic [2*n-1:0]  w_o16;
  logic            w_err;

  // Ready depends only on the registered count: a full queue refuses a
  // push even when the FSM pops in the same cycle.
  assign cmd_ready = (r_count < c_DEPTH);
  assign w_push    = cmd_valid & cmd_ready;
  assign w_have    = (r_count != '0);
  assign w_pop     = w_have & ((r_state == c_IDLE) |
                               ((r_state == c_RESP) & rsp_ready));
  assign w_issue   = (r_state == c_ISSUE);

  // Range check done in double width, independent of the ALU result.
  assign w_a16 = {{n{1'b0}}, r_c_a};
  assign w_o16 = {{n{1'b0}}, (r_c_uas ? r_acc : r_c_b)};

  always_comb begin
    w_err = 1'b0;
    case (r_c_ope)
      c_OP_ADD: w_err = ((w_a16 + w_o16) > c_LIMIT);
      c_OP_SUB: w_err = (w_a16 < w_o16);
      c_OP_MUL: w_err = ((w_a16 * w_o16) > c_LIMIT);
      default:  w_err = 1'b0;
    endcase
  end

  // ALU operands are only presented during ISSUE; zero otherwise.
  assign alu_ope = w_issue ? r_c_ope : 3'b000;
  assign alu_uas = w_issue ? r_c_uas : 1'b0;
  assign alu_in1 = w_issue ? r_c_a   : '0;
  assign alu_in2 = w_issue ? r_c_b   : '0;
  assign alu_res = r_acc;
  assign acc     = r_acc;

  assign rsp_valid = (r_state == c_RESP);
  assign rsp_data  = r_rsp_data;
  assign rsp_err   = r_rsp_err;
  assign busy      = (r_state != c_IDLE) | w_have;

  // Queue storage needs no reset: entries are only read when count says so.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_ope[r_wptr] <= cmd_ope;
      r_mem_uas[r_wptr] <= cmd_uas;
      r_mem_a[r_wptr]   <= cmd_a;
      r_mem_b[r_wptr]   <= cmd_b;
    end
  end

  // Pointers and occupancy; pointers wrap naturally (DEPTH is a power of 2).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + c_AW'(1);
      if (w_pop)  r_rptr <= r_rptr + c_AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CW'(1);
        2'b01:   r_count <= r_count - c_CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Sequencing FSM, command register, accumulator and response registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= c_IDLE;
      r_c_ope    <= 3'b000;
      r_c_uas    <= 1'b0;
      r_c_a      <= '0;
      r_c_b      <= '0;
      r_acc      <= '0;
      r_rsp_data <= '0;
      r_rsp_err  <= 1'b0;
    end else begin
      if (w_pop) begin
        r_c_ope <= r_mem_ope[r_rptr];
        r_c_uas <= r_mem_uas[r_rptr];
        r_c_a   <= r_mem_a[r_rptr];
        r_c_b   <= r_mem_b[r_rptr];
      end
      case (r_state)
        c_IDLE: begin
          if (w_have) r_state <= c_ISSUE;
        end
        c_ISSUE: begin
          // A range error still updates the accumulator with the wrapped value.
          r_acc      <= alu_ans;
          r_rsp_data <= alu_ans;
          r_rsp_err  <= w_err;
          r_state    <= c_RESP;
        end
        c_RESP: begin
          if (rsp_ready) r_state <= w_have ? c_ISSUE : c_IDLE;
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_calc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_calc_sequencer
// Purpose  : Self-checking bench for calc_sequencer. Provides the combinational
//            ALU mux, a directed vector table, hand-written backpressure and
//            reset sequences, and a randomized run scored against an in-order
//            reference model of the calculator.
// Revision : 1.0  initial release
// ============================================================================
module tb_calc_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid, cmd_ready;
  logic [2:0] cmd_ope;
  logic       cmd_uas;
  logic [7:0] cmd_a, cmd_b;
  logic [2:0] alu_ope;
  logic       alu_uas;
  logic [7:0] alu_in1, alu_in2, alu_res, alu_ans;
  logic       rsp_valid, rsp_ready;
  logic [7:0] rsp_data;
  logic       rsp_err;
  logic [7:0] acc;
  logic       busy;

  always #5 clk = ~clk;

  calc_sequencer #(.DEPTH(4), .n(8)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_ope(cmd_ope), .cmd_uas(cmd_uas), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .alu_ope(alu_ope), .alu_uas(alu_uas), .alu_in1(alu_in1), .alu_in2(alu_in2),
    .alu_res(alu_res), .alu_ans(alu_ans),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err),
    .acc(acc), .busy(busy)
  );

  // Calculator semantics in plain integer arithmetic.
  function automatic logic [7:0] alu_fn(input logic [2:0] ope, input logic uas,
                                        input logic [7:0] in1, input logic [7:0] in2,
                                        input logic [7:0] res);
    int o, r, i1, rr;
    i1 = int'(in1);
    rr = int'(res);
    o  = uas ? rr : int'(in2);
    case (ope)
      3'd0: r = 0;
      3'd1: r = i1 + o;
      3'd2: r = i1 - o;
      3'd3: r = i1 * o;
      3'd4: r = i1 & o;
      3'd5: r = i1 | o;
      3'd6: r = uas ? (255 - rr) : (255 - i1);
      default: r = i1 ^ o;
    endcase
    return r[7:0];
  endfunction

  function automatic logic err_fn(input logic [2:0] ope, input logic uas,
                                  input logic [7:0] a, input logic [7:0] b,
                                  input logic [7:0] accv);
    int o, ai;
    ai = int'(a);
    o  = uas ? int'(accv) : int'(b);
    case (ope)
      3'd1:    return (ai + o) > 255;
      3'd2:    return ai < o;
      3'd3:    return (ai * o) > 255;
      default: return 1'b0;
    endcase
  endfunction

  always_comb alu_ans = alu_fn(alu_ope, alu_uas, alu_in1, alu_in2, alu_res);

  typedef struct {
    logic [2:0] ope;
    logic       uas;
    logic [7:0] a;
    logic [7:0] b;
  } cmd_t;

  typedef struct {
    logic [2:0] ope;
    logic       uas;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] d;
    logic       e;
  } vec_t;

  int   total = 0;
  int   bad   = 0;
  cmd_t sb[$];
  logic [7:0] m_acc;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive_cmd(input cmd_t c);
    cmd_ope = c.ope;
    cmd_uas = c.uas;
    cmd_a   = c.a;
    cmd_b   = c.b;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_cmd_ready"}, cmd_ready, 1);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_data"},  rsp_data,  0);
    chk({tag, "_rsp_err"},   rsp_err,   0);
    chk({tag, "_acc"},       acc,       0);
    chk({tag, "_alu_ope"},   alu_ope,   0);
    chk({tag, "_alu_uas"},   alu_uas,   0);
    chk({tag, "_alu_in1"},   alu_in1,   0);
    chk({tag, "_alu_in2"},   alu_in2,   0);
    chk({tag, "_alu_res"},   alu_res,   0);
    chk({tag, "_busy"},      busy,      0);
  endtask

  // Compare the response on the bus with the oldest outstanding command.
  task automatic check_resp(input string tag);
    cmd_t       c;
    logic [7:0] d;
    logic       e;
    if (sb.size() == 0) begin
      chk({tag, "_unexpected_rsp"}, 1, 0);
      return;
    end
    c = sb.pop_front();
    d = alu_fn(c.ope, c.uas, c.a, c.b, m_acc);
    e = err_fn(c.ope, c.uas, c.a, c.b, m_acc);
    chk({tag, "_data"}, rsp_data, d);
    chk({tag, "_err"},  rsp_err,  e);
    chk({tag, "_acc"},  acc,      d);
    m_acc = d;
  endtask

  vec_t tbl[9];
  cmd_t bp[6];

  initial begin
    int n, got, stale;
    cmd_t c;
    logic [7:0] d0;

    tbl[0] = '{3'd1, 1'b0, 8'd5,    8'd3,   8'd8,    1'b0};
    tbl[1] = '{3'd1, 1'b1, 8'd10,   8'd99,  8'd18,   1'b0};
    tbl[2] = '{3'd3, 1'b0, 8'd20,   8'd13,  8'd4,    1'b1};
    tbl[3] = '{3'd2, 1'b0, 8'd3,    8'd5,   8'd254,  1'b1};
    tbl[4] = '{3'd1, 1'b0, 8'd200,  8'd55,  8'd255,  1'b0};
    tbl[5] = '{3'd0, 1'b0, 8'd77,   8'd66,  8'd0,    1'b0};
    tbl[6] = '{3'd5, 1'b0, 8'h0F,   8'h00,  8'h0F,   1'b0};
    tbl[7] = '{3'd6, 1'b1, 8'h33,   8'h44,  8'hF0,   1'b0};
    tbl[8] = '{3'd7, 1'b1, 8'hFF,   8'h12,  8'h0F,   1'b0};

    rst = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b1;
    cmd_ope = 3'd0; cmd_uas = 1'b0; cmd_a = 8'd0; cmd_b = 8'd0;
    m_acc = 8'd0;
    @(negedge clk);
    @(negedge clk);
    check_reset("por");
    rst = 1'b1;

    // Directed vectors: one command at a time, latency and result checked.
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      chk("tbl_ready", cmd_ready, 1);
      cmd_valid = 1'b1;
      drive_cmd('{tbl[i].ope, tbl[i].uas, tbl[i].a, tbl[i].b});
      @(negedge clk);
      cmd_valid = 1'b0;
      n = 0;
      while (!rsp_valid && n < 20) begin
        @(negedge clk);
        n++;
      end
      chk("tbl_valid", rsp_valid, 1);
      chk("tbl_latency", n, 2);
      chk("tbl_data", rsp_data, tbl[i].d);
      chk("tbl_err", rsp_err, tbl[i].e);
      chk("tbl_acc", acc, tbl[i].d);
      m_acc = tbl[i].d;
      @(negedge clk);
    end

    // Backpressure: 6 adds offered continuously, only DEPTH+1 fit.
    for (int i = 0; i < 6; i++)
      bp[i] = '{3'd1, 1'b0, 8'(200 + i * 10), 8'(i * 20)};
    rsp_ready = 1'b0;
    @(negedge clk);
    n = 0;
    cmd_valid = 1'b1;
    drive_cmd(bp[0]);
    for (int k = 0; k < 10; k++) begin
      if (cmd_ready && cmd_valid) begin
        sb.push_back(bp[n]);
        n++;
      end
      @(negedge clk);
      if (n < 6) drive_cmd(bp[n]);
      else cmd_valid = 1'b0;
    end
    cmd_valid = 1'b0;
    chk("bp_accepted", n, 5);
    chk("bp_ready_low", cmd_ready, 0);
    chk("bp_valid", rsp_valid, 1);
    d0 = alu_fn(sb[0].ope, sb[0].uas, sb[0].a, sb[0].b, m_acc);
    for (int k = 0; k < 3; k++) begin
      chk("bp_stall_data", rsp_data, d0);
      chk("bp_stall_valid", rsp_valid, 1);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    got = 0;
    for (int k = 0; k < 60 && got < 5; k++) begin
      if (rsp_valid) begin
        check_resp("bp");
        got++;
      end
      @(negedge clk);
    end
    chk("bp_responses", got, 5);
    chk("bp_busy_low", busy, 0);

    // Randomized traffic scored against the in-order model.
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      cmd_valid = ($urandom_range(0, 2) != 0);
      c = '{3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
            8'($urandom_range(0, 255)), 8'($urandom_range(0, 255))};
      if ($urandom_range(0, 3) == 0) c.a = 8'($urandom_range(0, 15));
      drive_cmd(c);
      rsp_ready = ($urandom_range(0, 3) != 0);
      if (cmd_valid && cmd_ready) sb.push_back(c);
      if (rsp_valid && rsp_ready) check_resp("rnd");
    end
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      rsp_ready = 1'b1;
      if (rsp_valid) check_resp("drain");
      if (!busy) break;
    end
    chk("drain_busy", busy, 0);
    chk("drain_empty", sb.size(), 0);

    // Reset asserted while a response is stalled and two entries queued.
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      cmd_valid = 1'b1;
      drive_cmd('{3'd1, 1'b0, 8'(i + 1), 8'd7});
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("pend_valid", rsp_valid, 1);
    chk("pend_busy", busy, 1);
    chk("pend_acc", acc, 8);
    rst = 1'b0;
    #1;
    check_reset("rst_mid");
    @(negedge clk);
    rst = 1'b1;
    rsp_ready = 1'b1;
    sb.delete();
    m_acc = 8'd0;
    stale = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (rsp_valid || busy) stale++;
    end
    chk("post_rst_stale", stale, 0);
    chk("post_rst_acc", acc, 0);
    chk("post_rst_ready", cmd_ready, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
